// File: rtl/fft_input_reorder_if.sv
// fft_input_reorder_if: sample stream in, bit-reversed pair stream out.
interface fft_input_reorder_if #(parameter int DW = 32);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          fft_idle_i;
    logic          start_o;
    logic [DW-1:0] x0_re_o;
    logic [DW-1:0] x0_im_o;
    logic [DW-1:0] x1_re_o;
    logic [DW-1:0] x1_im_o;
    logic          frame_done_o;
    logic [1:0]    bank_full_o;
    modport slave (
        input  in_valid, in_re, in_im, fft_idle_i,
        output in_ready, start_o, x0_re_o, x0_im_o, x1_re_o, x1_im_o, frame_done_o, bank_full_o
    );
    modport master (
        output in_valid, in_re, in_im, fft_idle_i,
        input  in_ready, start_o, x0_re_o, x0_im_o, x1_re_o, x1_im_o, frame_done_o, bank_full_o
    );
endinterface

// File: rtl/fft_input_reorder.sv
// fft_input_reorder: ping-pong frame buffer replaying N-sample frames as bit-reversed x0/x1 pairs.
module fft_input_reorder #(
    parameter  int N     = 1024,
    parameter  int DW    = 32,
    localparam int LOG2N = $clog2(N)
) (
    input logic clk,
    input logic rstn,
    fft_input_reorder_if.slave bus
);
    localparam int HW = LOG2N - 1;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state_q, state_d;
    logic [1:0] bank_full_q, bank_full_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [HW-1:0] k_q, k_d, rd_addr;
    logic start_q, done_q;
    logic [2*DW-1:0] x0_q, x1_q;
    logic wr_en, wr_last, streaming;
    // bitrev(2k) lands in the lower half and bitrev(2k+1) at the same offset in the upper half
    logic [2*DW-1:0] mem_lo [2][N/2];
    logic [2*DW-1:0] mem_hi [2][N/2];
    assign bus.in_ready     = !bank_full_q[wr_bank_q];
    assign wr_en            = bus.in_valid && bus.in_ready;
    assign wr_last          = wr_en && (wr_cnt_q == '1);
    assign streaming        = state_q == STREAM;
    assign bus.start_o      = start_q;
    assign bus.frame_done_o = done_q;
    assign bus.bank_full_o  = bank_full_q;
    assign {bus.x0_re_o, bus.x0_im_o} = x0_q;
    assign {bus.x1_re_o, bus.x1_im_o} = x1_q;
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < HW; i++) rd_addr[i] = k_q[HW-1-i];
    end
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        wr_cnt_d    = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d   = wr_last ? !wr_bank_q : wr_bank_q;
        if (wr_last) bank_full_d[wr_bank_q] = 1'b1;
        case (state_q)
            IDLE: if (bank_full_q[rd_bank_q] && bus.fft_idle_i) begin
                state_d = STREAM;
                k_d     = '0;
            end
            STREAM: begin
                k_d     = k_q + 1'b1;
                state_d = (k_q == '1) ? DRAIN : STREAM;
            end
            DRAIN: begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_bank_d              = !rd_bank_q;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rd_bank_q   <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            bank_full_q <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_bank_q   <= rd_bank_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            bank_full_q <= bank_full_d;
            start_q     <= streaming;
            done_q      <= streaming && (k_q == '1);
            x0_q        <= streaming ? mem_lo[rd_bank_q][rd_addr] : '0;
            x1_q        <= streaming ? mem_hi[rd_bank_q][rd_addr] : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en && wr_cnt_q[LOG2N-1]) mem_hi[wr_bank_q][wr_cnt_q[HW-1:0]] <= {bus.in_re, bus.in_im};
        if (wr_en && !wr_cnt_q[LOG2N-1]) mem_lo[wr_bank_q][wr_cnt_q[HW-1:0]] <= {bus.in_re, bus.in_im};
    end
endmodule
